// File: rtl/alu_pkg.sv
// Shared types for the ALU sequencing front-end: opcodes, status flags, FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_MOD = 3'b100
  } op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
    logic dz;
  } flags_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu.sv
// Combinational signed ALU. Results are truncated to WIDTH bits; the full-width
// product is exported so the caller can judge multiply overflow.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]               op,
  input  logic signed [WIDTH-1:0]  a,
  input  logic signed [WIDTH-1:0]  b,
  output logic signed [WIDTH-1:0]  res,
  output logic signed [2*WIDTH-1:0] prod
);

  logic signed [2*WIDTH-1:0] a_w;
  logic signed [2*WIDTH-1:0] b_w;

  // Operation select; division/modulo truncate toward zero, modulo takes the sign of a.
  always_comb begin
    a_w  = {{WIDTH{a[WIDTH-1]}}, a};
    b_w  = {{WIDTH{b[WIDTH-1]}}, b};
    prod = a_w * b_w;
    res  = a;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_MUL:  res = prod[WIDTH-1:0];
      OP_DIV:  res = a / b;
      OP_MOD:  res = a % b;
      default: res = a;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Valid/ready sequencer around the signed alu: latch request, execute for one
// cycle, hold the flagged response until accepted, count ops and div-by-zero errors.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [2:0]              req_op,
  input  logic signed [WIDTH-1:0] req_a,
  input  logic signed [WIDTH-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic signed [WIDTH-1:0] rsp_data,
  output flags_t                  rsp_flags,
  output logic [CNT_W-1:0]        op_count,
  output logic [CNT_W-1:0]        err_count
);

  localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] ONE_V = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic signed [WIDTH-1:0] NEG1  = {WIDTH{1'b1}};

  state_e state_q, state_d;
  logic   load_p0, exec_p1, hs;

  logic [2:0]                op_p0;
  logic signed [WIDTH-1:0]   a_p0, b_p0;

  logic                      dz_p1;
  logic signed [WIDTH-1:0]   b_alu, alu_res, res_p1;
  logic signed [2*WIDTH-1:0] prod_p1;
  flags_t                    flags_p1;

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] x, y, r);
    return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x, y, r);
    return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  function automatic logic mul_ovf(input logic signed [2*WIDTH-1:0] p,
                                   input logic signed [WIDTH-1:0] r);
    return p != {{WIDTH{r[WIDTH-1]}}, r};
  endfunction

  function automatic logic div_ovf(input logic signed [WIDTH-1:0] x, y);
    return (x == MIN_V) && (y == NEG1);
  endfunction

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    load_p0   = 1'b0;
    exec_p1   = 1'b0;
    hs        = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          load_p0 = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        exec_p1 = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          hs      = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- stage p0: operand capture on request handshake ----
  // Operand registers; plain data, no reset needed.
  always_ff @(posedge clk) begin
    if (load_p0) begin
      op_p0 <= req_op;
      a_p0  <= req_a;
      b_p0  <= req_b;
    end
  end

  // ---- stage p1: execute on latched operands ----
  // Zero-divisor guard keeps the divider away from b=0.
  always_comb begin
    dz_p1 = ((op_p0 == OP_DIV) || (op_p0 == OP_MOD)) && (b_p0 == '0);
    b_alu = dz_p1 ? ONE_V : b_p0;
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .op   (op_p0),
    .a    (a_p0),
    .b    (b_alu),
    .res  (alu_res),
    .prod (prod_p1)
  );

  // Result forcing and status flags.
  always_comb begin
    res_p1      = dz_p1 ? '0 : alu_res;
    flags_p1    = '0;
    flags_p1.z  = (res_p1 == '0);
    flags_p1.n  = res_p1[WIDTH-1];
    flags_p1.dz = dz_p1;
    if (!dz_p1) begin
      case (op_p0)
        OP_ADD:  flags_p1.v = add_ovf(a_p0, b_p0, res_p1);
        OP_SUB:  flags_p1.v = sub_ovf(a_p0, b_p0, res_p1);
        OP_MUL:  flags_p1.v = mul_ovf(prod_p1, res_p1);
        OP_DIV:  flags_p1.v = div_ovf(a_p0, b_p0);
        default: flags_p1.v = 1'b0;
      endcase
    end
  end

  // ---- stage p2: response held until consumer accepts ----
  // Response registers; cleared on reset so a dropped op leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data  <= '0;
      rsp_flags <= '0;
    end else if (exec_p1) begin
      rsp_data  <= res_p1;
      rsp_flags <= flags_p1;
    end
  end

  // Completed-op and div-by-zero counters, wrapping silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count  <= '0;
      err_count <= '0;
    end else if (hs) begin
      op_count  <= op_count + CNT_W'(1);
      err_count <= err_count + CNT_W'(rsp_flags.dz);
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed cases, backpressure, mid-op reset,
// and randomized ops against a plain-arithmetic reference model.
module tb_alu_seq_ctrl;
  import alu_pkg::*;

  localparam int W  = 8;
  localparam int CW = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                req_valid;
  logic                req_ready;
  logic [2:0]          req_op;
  logic signed [W-1:0] req_a, req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic signed [W-1:0] rsp_data;
  flags_t              rsp_flags;
  logic [CW-1:0]       op_count, err_count;

  int checks = 0;
  int errors = 0;
  int op_m   = 0;
  int err_m  = 0;

  alu_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_flags (rsp_flags),
    .op_count  (op_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: exact integer arithmetic, then truncate; overflow = truncated value differs.
  function automatic void ref_op(input logic [2:0] op, input logic signed [W-1:0] a,
                                 input logic signed [W-1:0] b,
                                 output logic signed [W-1:0] d, output logic [3:0] f);
    longint sa, sb, full;
    logic v, dz;
    sa = a; sb = b; full = 0; v = 1'b0; dz = 1'b0;
    case (op)
      3'd0: full = sa + sb;
      3'd1: full = sa - sb;
      3'd2: full = sa * sb;
      3'd3: if (sb == 0) dz = 1'b1; else full = sa / sb;
      3'd4: if (sb == 0) dz = 1'b1; else full = sa % sb;
      default: full = sa;
    endcase
    d = dz ? '0 : full[W-1:0];
    if (!dz && op <= 3'd3) v = (full != longint'(d));
    f = {(d == '0), d[W-1], v, dz};
  endfunction

  // Drive one request, wait for the response, optionally stall, then accept it.
  task automatic run_op(input logic [2:0] op, input logic signed [W-1:0] a,
                        input logic signed [W-1:0] b, input int hold,
                        output int lat, output logic signed [W-1:0] d,
                        output logic [3:0] f);
    int w;
    logic signed [W-1:0] md;
    logic [3:0] mf;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    d = rsp_data;
    f = rsp_flags;
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    ref_op(op, a, b, md, mf);
    if (lat < 10) begin
      op_m++;
      err_m += int'(mf[0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    op_m = 0; err_m = 0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data got=%0d exp=0", rsp_data); end
    checks++; if (rsp_flags !== 4'b0000) begin errors++; $display("FAIL reset_rsp_flags got=%b exp=0000", rsp_flags); end
    checks++; if (op_count !== '0) begin errors++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
    checks++; if (err_count !== '0) begin errors++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_directed();
    logic [2:0]          t_op [7] = '{3'd0, 3'd1, 3'd0, 3'd2, 3'd3, 3'd4, 3'd7};
    logic signed [W-1:0] t_a  [7] = '{8'sd100, 8'sd5, 8'sd100, 8'sd16, 8'sh80, -8'sd7, 8'sd42};
    logic signed [W-1:0] t_b  [7] = '{8'sd27, 8'sd9, 8'sd28, 8'sd8, 8'shFF, 8'sd2, 8'sd0};
    logic signed [W-1:0] e_d  [7] = '{8'sd127, 8'shFC, 8'sh80, 8'sh80, 8'sh80, 8'shFF, 8'sd42};
    logic [3:0]          e_f  [7] = '{4'b0000, 4'b0100, 4'b0110, 4'b0110, 4'b0110, 4'b0100, 4'b0000};
    int lat;
    logic signed [W-1:0] d;
    logic [3:0] f;
    for (int i = 0; i < 7; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], 0, lat, d, f);
      checks++; if (lat !== 2) begin errors++; $display("FAIL directed%0d_latency got=%0d exp=2", i, lat); end
      checks++; if (d !== e_d[i]) begin errors++; $display("FAIL directed%0d_data got=%0d exp=%0d", i, d, e_d[i]); end
      checks++; if (f !== e_f[i]) begin errors++; $display("FAIL directed%0d_flags got=%b exp=%b", i, f, e_f[i]); end
    end
    checks++; if (op_count !== CW'(op_m)) begin errors++; $display("FAIL directed_op_count got=%0d exp=%0d", op_count, op_m); end
  endtask

  task automatic test_div_zero();
    int lat;
    logic signed [W-1:0] d;
    logic [3:0] f;
    run_op(3'd3, 8'sd7, 8'sd0, 0, lat, d, f);
    checks++; if (d !== '0) begin errors++; $display("FAIL div0_data got=%0d exp=0", d); end
    checks++; if (f !== 4'b1001) begin errors++; $display("FAIL div0_flags got=%b exp=1001", f); end
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL div0_err_count got=%0d exp=1", err_count); end
    run_op(3'd4, -8'sd7, 8'sd0, 1, lat, d, f);
    checks++; if (d !== '0) begin errors++; $display("FAIL mod0_data got=%0d exp=0", d); end
    checks++; if (f !== 4'b1001) begin errors++; $display("FAIL mod0_flags got=%b exp=1001", f); end
    checks++; if (err_count !== 16'd2) begin errors++; $display("FAIL mod0_err_count got=%0d exp=2", err_count); end
    checks++; if (op_count !== CW'(op_m)) begin errors++; $display("FAIL div0_op_count got=%0d exp=%0d", op_count, op_m); end
  endtask

  task automatic test_backpressure();
    int w;
    logic signed [W-1:0] d0;
    logic [3:0] f0;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    req_valid = 1'b1; req_op = 3'd2; req_a = -8'sd3; req_b = 8'sd7;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid got=%b exp=1", rsp_valid); end
    d0 = rsp_data; f0 = rsp_flags;
    checks++; if (d0 !== -8'sd21 || f0 !== 4'b0100) begin errors++; $display("FAIL bp_first_result got=%0d/%b exp=-21/0100", d0, f0); end
    req_valid = 1'b1; req_op = 3'd0; req_a = 8'sd3; req_b = 8'sd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_flags !== f0 || req_ready !== 1'b0 || op_count !== CW'(op_m)) begin
        errors++;
        $display("FAIL bp_hold%0d got valid=%b data=%0d flags=%b rdy=%b cnt=%0d exp valid=1 data=%0d flags=%b rdy=0 cnt=%0d",
                 i, rsp_valid, rsp_data, rsp_flags, req_ready, op_count, d0, f0, op_m);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    op_m++;
    checks++; if (op_count !== CW'(op_m)) begin errors++; $display("FAIL bp_release_count got=%0d exp=%0d", op_count, op_m); end
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_idle got rdy=%b valid=%b exp rdy=1 valid=0", req_ready, rsp_valid); end
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accept got rdy=%b exp=0", req_ready); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'sd7) begin errors++; $display("FAIL bp_next_result got valid=%b data=%0d exp valid=1 data=7", rsp_valid, rsp_data); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    op_m++;
    checks++; if (op_count !== CW'(op_m)) begin errors++; $display("FAIL bp_final_count got=%0d exp=%0d", op_count, op_m); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic signed [W-1:0] d;
    logic [3:0] f;
    // reset while in EXEC
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; req_a = 8'sd50; req_b = 8'sd50;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    op_m = 0; err_m = 0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_exec_hs got valid=%b rdy=%b exp valid=0 rdy=1", rsp_valid, req_ready); end
    checks++; if (op_count !== '0 || err_count !== '0 || rsp_data !== '0) begin errors++; $display("FAIL rst_exec_regs got cnt=%0d err=%0d data=%0d exp 0 0 0", op_count, err_count, rsp_data); end
    // reset while in RESP with a pending div-by-zero response being accepted
    req_valid = 1'b1; req_op = 3'd3; req_a = 8'sd5; req_b = 8'sd0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_flags !== 4'b1001) begin errors++; $display("FAIL rst_resp_pending got valid=%b flags=%b exp valid=1 flags=1001", rsp_valid, rsp_flags); end
    rst = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_resp_hs got valid=%b rdy=%b exp valid=0 rdy=1", rsp_valid, req_ready); end
    checks++; if (op_count !== '0 || err_count !== '0 || rsp_flags !== 4'b0000) begin errors++; $display("FAIL rst_resp_regs got cnt=%0d err=%0d flags=%b exp 0 0 0000", op_count, err_count, rsp_flags); end
    run_op(3'd0, 8'sd1, 8'sd1, 0, lat, d, f);
    checks++; if (d !== 8'sd2 || f !== 4'b0000) begin errors++; $display("FAIL rst_after_add got=%0d/%b exp=2/0000", d, f); end
    checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL rst_after_count got=%0d exp=1", op_count); end
  endtask

  task automatic test_random();
    int lat;
    logic [2:0] op;
    logic signed [W-1:0] a, b, d, md;
    logic [3:0] f, mf;
    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom());
      b  = ($urandom_range(0, 5) == 0) ? 8'sd0 : 8'($urandom());
      if ($urandom_range(0, 7) == 0) a = 8'sh80;
      if ($urandom_range(0, 7) == 0) b = 8'shFF;
      run_op(op, a, b, $urandom_range(0, 3), lat, d, f);
      ref_op(op, a, b, md, mf);
      checks++;
      if (lat !== 2 || d !== md || f !== mf) begin
        errors++;
        $display("FAIL rand%0d op=%0d a=%0d b=%0d got lat=%0d data=%0d flags=%b exp lat=2 data=%0d flags=%b",
                 i, op, a, b, lat, d, f, md, mf);
      end
    end
    checks++; if (op_count !== CW'(op_m)) begin errors++; $display("FAIL rand_op_count got=%0d exp=%0d", op_count, op_m); end
    checks++; if (err_count !== CW'(err_m)) begin errors++; $display("FAIL rand_err_count got=%0d exp=%0d", err_count, err_m); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
